counter_mode_sequencer: RTL and testbench

Programmable step sequencer that drives the enable and mode inputs of universal_counter. It holds a small table of steps, each with a counter mode, a duration in cycles and a last flag. On start it plays the steps back-to-back with no gap cycles, optionally looping, and reports busy, done and abort status. It sits between the control/config logic and one universal_counter instance.

---
 rtl/counter_mode_sequencer.sv | 166 ++++++++++++++++
 tb/tb_counter_mode_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_mode_sequencer.sv
// Step sequencer that drives the enable and mode inputs of a universal_counter.
// A small table of {mode, duration, last} steps is played back-to-back with no
// gap cycles, optionally looping, with busy/done/aborted status. All outputs
// are registered; reset is synchronous and active-low.
module counter_mode_sequencer #(
  parameter int NUM_STEPS = 4,
  parameter int STEP_AW   = 2,
  parameter int DUR_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [STEP_AW-1:0] cfg_addr,
  input  logic [1:0]         cfg_mode,
  input  logic [DUR_W-1:0]   cfg_dur,
  input  logic               cfg_last,
  input  logic               start,
  input  logic               abort,
  input  logic               loop_en,
  output logic               cnt_enable,
  output logic [1:0]         cnt_mode,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [STEP_AW-1:0] step_idx,
  output logic [DUR_W-1:0]   remaining
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic                 cnt_enable_q, cnt_enable_d;
  logic [1:0]           cnt_mode_q, cnt_mode_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 aborted_q, aborted_d;
  logic [STEP_AW-1:0]   step_idx_q, step_idx_d;
  logic [DUR_W-1:0]     remaining_q, remaining_d;

  // Step table; frozen while a program is running.
  logic [1:0]           tbl_mode_q [NUM_STEPS];
  logic [DUR_W-1:0]     tbl_dur_q  [NUM_STEPS];
  logic [NUM_STEPS-1:0] tbl_last_q;

  logic                 tbl_we_s;
  logic                 end_step_s;
  logic [STEP_AW-1:0]   next_idx_s;

  assign tbl_we_s   = cfg_we && (state_q == ST_IDLE);
  // The last table slot always ends the program even without its last flag.
  assign end_step_s = tbl_last_q[step_idx_q] || (step_idx_q == STEP_AW'(NUM_STEPS - 1));
  assign next_idx_s = step_idx_q + STEP_AW'(1);

  // Table storage: cleared on reset, written only while idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        tbl_mode_q[i] <= 2'b00;
        tbl_dur_q[i]  <= {DUR_W{1'b0}};
      end
      tbl_last_q <= {NUM_STEPS{1'b0}};
    end else if (tbl_we_s) begin
      tbl_mode_q[cfg_addr] <= cfg_mode;
      tbl_dur_q[cfg_addr]  <= cfg_dur;
      tbl_last_q[cfg_addr] <= cfg_last;
    end
  end

  // FSM and registered output state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_enable_q <= 1'b0;
      cnt_mode_q   <= 2'b00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      step_idx_q   <= {STEP_AW{1'b0}};
      remaining_q  <= {DUR_W{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_enable_q <= cnt_enable_d;
      cnt_mode_q   <= cnt_mode_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      step_idx_q   <= step_idx_d;
      remaining_q  <= remaining_d;
    end
  end

  // Next-state and next-output logic; pulses default low, index/count hold.
  always_comb begin
    state_d      = state_q;
    cnt_enable_d = cnt_enable_q;
    cnt_mode_d   = cnt_mode_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    step_idx_d   = step_idx_q;
    remaining_d  = remaining_q;
    case (state_q)
      ST_IDLE: begin
        cnt_enable_d = 1'b0;
        cnt_mode_d   = 2'b00;
        busy_d       = 1'b0;
        if (start && !abort) begin
          state_d      = ST_RUN;
          step_idx_d   = {STEP_AW{1'b0}};
          remaining_d  = tbl_dur_q[0];
          cnt_mode_d   = tbl_mode_q[0];
          cnt_enable_d = 1'b1;
          busy_d       = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d      = ST_IDLE;
          cnt_enable_d = 1'b0;
          cnt_mode_d   = 2'b00;
          busy_d       = 1'b0;
          aborted_d    = 1'b1;
        end else if (remaining_q == DUR_W'(1)) begin
          if (!end_step_s) begin
            step_idx_d  = next_idx_s;
            remaining_d = tbl_dur_q[next_idx_s];
            cnt_mode_d  = tbl_mode_q[next_idx_s];
          end else if (loop_en) begin
            step_idx_d  = {STEP_AW{1'b0}};
            remaining_d = tbl_dur_q[0];
            cnt_mode_d  = tbl_mode_q[0];
          end else begin
            state_d      = ST_IDLE;
            cnt_enable_d = 1'b0;
            cnt_mode_d   = 2'b00;
            busy_d       = 1'b0;
            done_d       = 1'b1;
          end
        end else begin
          // A loaded 0 wraps here, giving a full 2^DUR_W-cycle step.
          remaining_d = remaining_q - DUR_W'(1);
        end
      end
      default: begin
        state_d      = ST_IDLE;
        cnt_enable_d = 1'b0;
        cnt_mode_d   = 2'b00;
        busy_d       = 1'b0;
      end
    endcase
  end

  assign cnt_enable = cnt_enable_q;
  assign cnt_mode   = cnt_mode_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign step_idx   = step_idx_q;
  assign remaining  = remaining_q;

endmodule

// File: tb/tb_counter_mode_sequencer.sv
// Self-checking bench for counter_mode_sequencer: a behavioural reference
// model produces the expected outputs for every driven cycle into a scoreboard
// queue, which is popped and compared after the clock edge; directed scenario
// counts (enabled cycles, mode dwell, pulses) are checked against constants.
module tb_counter_mode_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = 2'd0;
  logic [1:0] cfg_mode = 2'd0;
  logic [7:0] cfg_dur = 8'd0;
  logic       cfg_last = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       loop_en = 1'b0;
  logic       cnt_enable;
  logic [1:0] cnt_mode;
  logic       busy, done, aborted;
  logic [1:0] step_idx;
  logic [7:0] remaining;

  counter_mode_sequencer #(.NUM_STEPS(4), .STEP_AW(2), .DUR_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_mode(cfg_mode), .cfg_dur(cfg_dur), .cfg_last(cfg_last),
    .start(start), .abort(abort), .loop_en(loop_en),
    .cnt_enable(cnt_enable), .cnt_mode(cnt_mode), .busy(busy), .done(done),
    .aborted(aborted), .step_idx(step_idx), .remaining(remaining)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    logic [1:0] mode;
    logic       busy;
    logic       done;
    logic       ab;
    logic [1:0] idx;
    logic [7:0] rem;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model state.
  logic       m_run;
  exp_t       m;
  logic [1:0] t_mode [4];
  int         t_len  [4];   // true step length in cycles (1..256)
  logic       t_last [4];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void load_step(input int i);
    m.idx  = 2'(i);
    m.rem  = 8'(t_len[i]);   // 256 encodes as 0
    m.mode = t_mode[i];
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    m.done = 1'b0;
    m.ab   = 1'b0;
    if (!rst) begin
      m = '0;
      m_run = 1'b0;
      for (int i = 0; i < 4; i++) begin
        t_mode[i] = 2'b00; t_len[i] = 256; t_last[i] = 1'b0;
      end
    end else if (!m_run) begin
      if (start && !abort) begin
        m_run = 1'b1; m.en = 1'b1; m.busy = 1'b1;
        load_step(0);
      end
      if (cfg_we) begin
        t_mode[cfg_addr] = cfg_mode;
        t_len[cfg_addr]  = (cfg_dur == 8'd0) ? 256 : int'(cfg_dur);
        t_last[cfg_addr] = cfg_last;
      end
    end else if (abort) begin
      m_run = 1'b0; m.en = 1'b0; m.mode = 2'b00; m.busy = 1'b0; m.ab = 1'b1;
    end else if (m.rem != 8'd1) begin
      m.rem = m.rem - 8'd1;
    end else if (!t_last[m.idx] && m.idx != 2'd3) begin
      load_step(int'(m.idx) + 1);
    end else if (loop_en) begin
      load_step(0);
    end else begin
      m_run = 1'b0; m.en = 1'b0; m.mode = 2'b00; m.busy = 1'b0; m.done = 1'b1;
    end
  endtask

  // One clock: push the model prediction, clock, pop and compare.
  task automatic cyc();
    exp_t e;
    model_step();
    sb_q.push_back(m);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq("cnt_enable", 32'(cnt_enable), 32'(e.en));
    check_eq("cnt_mode",   32'(cnt_mode),   32'(e.mode));
    check_eq("busy",       32'(busy),       32'(e.busy));
    check_eq("done",       32'(done),       32'(e.done));
    check_eq("aborted",    32'(aborted),    32'(e.ab));
    check_eq("step_idx",   32'(step_idx),   32'(e.idx));
    check_eq("remaining",  32'(remaining),  32'(e.rem));
    if (done && aborted) check_eq("done_and_aborted", 32'd1, 32'd0);
  endtask

  task automatic cfg(input int a, input logic [1:0] md, input int d, input logic l);
    cfg_we = 1'b1; cfg_addr = 2'(a); cfg_mode = md; cfg_dur = 8'(d); cfg_last = l;
    cyc();
    cfg_we = 1'b0;
  endtask

  // Pulse start, then run until done/aborted is seen or the budget expires.
  task automatic run_prog(input int budget, output int en_cnt, output int done_cnt,
                          output int mc0, output int mc1, output int mc2, output int mc3);
    bit fin;
    en_cnt = 0; done_cnt = 0; mc0 = 0; mc1 = 0; mc2 = 0; mc3 = 0; fin = 0;
    start = 1'b1;
    for (int i = 0; i < budget && !fin; i++) begin
      cyc();
      start = 1'b0;
      if (cnt_enable) begin
        en_cnt++;
        case (cnt_mode)
          2'd0: mc0++;
          2'd1: mc1++;
          2'd2: mc2++;
          default: mc3++;
        endcase
      end
      if (done) done_cnt++;
      if (done || aborted) fin = 1;
    end
    if (!fin) check_eq("run_timeout", 32'd0, 32'd1);
  endtask

  int en_c, dn_c, c0, c1, c2, c3;

  initial begin
    m = '0; m_run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      t_mode[i] = 2'b00; t_len[i] = 256; t_last[i] = 1'b0;
    end

    // 1. Reset with start held; then the cleared table: 4 x 256 cycles of mode 00.
    rst = 1'b0; start = 1'b1;
    cyc(); cyc();
    start = 1'b0; rst = 1'b1;
    cyc();
    run_prog(1100, en_c, dn_c, c0, c1, c2, c3);
    check_eq("t1_enabled_cycles", 32'(en_c), 32'd1024);
    check_eq("t1_mode00_cycles", 32'(c0), 32'd1024);
    check_eq("t1_done_count", 32'(dn_c), 32'd1);
    cyc();
    check_eq("t1_done_one_cycle", 32'(done), 32'd0);

    // 2. Two-step program.
    cfg(0, 2'b01, 10, 1'b0);
    cfg(1, 2'b10, 5, 1'b1);
    run_prog(40, en_c, dn_c, c0, c1, c2, c3);
    check_eq("t2_enabled_cycles", 32'(en_c), 32'd15);
    check_eq("t2_mode01_cycles", 32'(c1), 32'd10);
    check_eq("t2_mode10_cycles", 32'(c2), 32'd5);
    check_eq("t2_done_count", 32'(dn_c), 32'd1);
    check_eq("t2_step_idx_end", 32'(step_idx), 32'd1);
    cyc();
    check_eq("t2_busy_after", 32'(busy), 32'd0);

    // 3. Looping single step, then finish the current pass.
    cfg(0, 2'b11, 3, 1'b1);
    loop_en = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    dn_c = 0; en_c = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (done) dn_c++;
      if (cnt_enable && cnt_mode == 2'b11) en_c++;
    end
    check_eq("t3_loop_no_done", 32'(dn_c), 32'd0);
    check_eq("t3_loop_enabled", 32'(en_c), 32'd12);
    loop_en = 1'b0;
    dn_c = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (done) dn_c++;
    end
    check_eq("t3_single_done", 32'(dn_c), 32'd1);

    // 4. Abort in cycle 4 of a 10-cycle step, then restart.
    cfg(0, 2'b01, 10, 1'b1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc(); cyc();
    check_eq("t4_rem_before_abort", 32'(remaining), 32'd7);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check_eq("t4_aborted", 32'(aborted), 32'd1);
    check_eq("t4_en_off", 32'(cnt_enable), 32'd0);
    check_eq("t4_no_done", 32'(done), 32'd0);
    cyc();
    check_eq("t4_aborted_pulse", 32'(aborted), 32'd0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check_eq("t4_restart_idx", 32'(step_idx), 32'd0);
    check_eq("t4_restart_rem", 32'(remaining), 32'd10);
    for (int i = 0; i < 12; i++) cyc();

    // 5a. dur=0 means 256 cycles.
    cfg(0, 2'b01, 0, 1'b1);
    run_prog(300, en_c, dn_c, c0, c1, c2, c3);
    check_eq("t5_dur0_cycles", 32'(c1), 32'd256);
    // 5b. No last flag: all four steps play.
    for (int i = 0; i < 4; i++) cfg(i, 2'(i), 2, 1'b0);
    run_prog(20, en_c, dn_c, c0, c1, c2, c3);
    check_eq("t5_nolast_cycles", 32'(en_c), 32'd8);
    check_eq("t5_nolast_mode11", 32'(c3), 32'd2);
    check_eq("t5_nolast_done", 32'(dn_c), 32'd1);
    // 5c. start with abort in IDLE stays idle.
    start = 1'b1; abort = 1'b1;
    cyc();
    start = 1'b0; abort = 1'b0;
    check_eq("t5_start_abort_busy", 32'(busy), 32'd0);
    check_eq("t5_start_abort_pulse", 32'(aborted), 32'd0);
    cyc();

    // 6. Config and start ignored while running.
    cfg(0, 2'b01, 4, 1'b0);
    cfg(1, 2'b10, 4, 1'b1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_mode = 2'b11; cfg_dur = 8'd9; cfg_last = 1'b1;
    start = 1'b1;
    cyc();
    cfg_we = 1'b0; start = 1'b0;
    check_eq("t6_no_restart_rem", 32'(remaining), 32'd2);
    for (int i = 0; i < 8; i++) cyc();
    run_prog(20, en_c, dn_c, c0, c1, c2, c3);
    check_eq("t6_old_entry_cycles", 32'(en_c), 32'd8);
    check_eq("t6_no_mode11", 32'(c3), 32'd0);

    // Mid-run reset: full reset state, no pulses.
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    check_eq("rst_mid_pulses", 32'({done, aborted}), 32'd0);
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
